// File: rtl/sramlike_arb_pkg.sv
// sramlike_arb_pkg: shared state, owner and size encodings for the sram-like arbiter.
package sramlike_arb_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    localparam logic OWN_DATA = 1'b0;
    localparam logic OWN_INST = 1'b1;
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/sramlike_arb_pick.sv
// sramlike_arb_pick: combinational winner select; data wins unless starve forces inst.
module sramlike_arb_pick
    import sramlike_arb_pkg::*;
(
    input  logic d_req,
    input  logic i_req,
    input  logic starve,
    output logic valid,
    output logic owner
);
    assign valid = d_req | i_req;
    assign owner = (i_req && (!d_req || starve)) ? OWN_INST : OWN_DATA;
endmodule

// File: rtl/sramlike_arbiter.sv
// sramlike_arbiter: shares one sram-like master port between inst and data requesters.
// Optional ARB_STARVE_EN forces an inst grant after STARVE_LIMIT consecutive data grants.
module sramlike_arbiter
    import sramlike_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata
);
    state_t state;
    logic   owner;
    logic   starve;
    logic   pick_valid;
    logic   pick_owner;
    logic   addr_hit;
    logic   done;

    sramlike_arb_pick u_pick (
        .d_req (d_req),
        .i_req (i_req),
        .starve(starve),
        .valid (pick_valid),
        .owner (pick_owner)
    );

`ifdef ARB_STARVE_EN
    logic [2:0] starve_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve_cnt <= '0;
        else if (state == IDLE && pick_valid)
            starve_cnt <= (pick_owner == OWN_INST) ? 3'd0 :
                          (i_req && starve_cnt != 3'd7) ? starve_cnt + 3'd1 : starve_cnt;
    end
    assign starve = i_req && (starve_cnt == 3'(STARVE_LIMIT));
`else
    logic unused_starve_limit;
    assign unused_starve_limit = STARVE_LIMIT[0];
    assign starve = 1'b0;
`endif

    // Completion can come with the accept in REQ or later in WAIT; IDLE data_ok is spurious.
    assign addr_hit = (state == REQ) && m_addr_ok;
    assign done     = m_data_ok && (addr_hit || state == WAIT);

    assign i_addr_ok = addr_hit && owner == OWN_INST;
    assign d_addr_ok = addr_hit && owner == OWN_DATA;
    assign i_data_ok = done && owner == OWN_INST;
    assign d_data_ok = done && owner == OWN_DATA;
    assign i_rdata   = (owner == OWN_INST) ? m_rdata : '0;
    assign d_rdata   = (owner == OWN_DATA) ? m_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= OWN_DATA;
            m_req   <= 1'b0;
            m_wr    <= 1'b0;
            m_size  <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    owner   <= pick_owner;
                    m_wr    <= (pick_owner == OWN_INST) ? i_wr    : d_wr;
                    m_size  <= (pick_owner == OWN_INST) ? i_size  : d_size;
                    m_addr  <= (pick_owner == OWN_INST) ? i_addr  : d_addr;
                    m_wdata <= (pick_owner == OWN_INST) ? i_wdata : d_wdata;
                    m_req   <= 1'b1;
                    state   <= REQ;
                end
                REQ: if (m_addr_ok) begin
                    m_req <= 1'b0;
                    state <= m_data_ok ? IDLE : WAIT;
                end
                WAIT: if (m_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sramlike_arbiter.sv
// tb_sramlike_arbiter: directed self-checking bench for sramlike_arbiter.
// Build with ARB_STARVE_EN defined to expect the starvation grant order.
module tb_sramlike_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, i_wr = 1'b0, d_req = 1'b0, d_wr = 1'b0;
    logic [1:0]  i_size = '0, d_size = '0;
    logic [31:0] i_addr = '0, i_wdata = '0, d_addr = '0, d_wdata = '0;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
    logic [31:0] m_rdata = '0;
    int          checks = 0;
    int          errors = 0;

    sramlike_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic resp(input string tag, input logic inst, input logic [31:0] rd);
        check({tag, "_idok"}, i_data_ok, inst);
        check({tag, "_ddok"}, d_data_ok, !inst);
        check({tag, "_irdata"}, i_rdata, inst ? rd : 32'h0);
        check({tag, "_drdata"}, d_rdata, inst ? 32'h0 : rd);
    endtask

    // Acts as the downstream: waits for m_req, accepts, then completes (same cycle or one later).
    task automatic serve(input string tag, input logic inst, input logic [31:0] addr,
                         input logic same, input logic [31:0] rd, input logic drop);
        int n = 0;
        while (!m_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_mreq"}, m_req, 1);
        check({tag, "_maddr"}, m_addr, addr);
        m_addr_ok = 1'b1;
        m_data_ok = same;
        m_rdata   = same ? rd : 32'h0;
        #1;
        check({tag, "_iaok"}, i_addr_ok, inst);
        check({tag, "_daok"}, d_addr_ok, !inst);
        if (same) resp(tag, inst, rd);
        tick();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = 32'h0;
        if (drop) begin
            if (inst) i_req = 1'b0;
            else d_req = 1'b0;
        end
        if (!same) begin
            #1;
            check({tag, "_wait_mreq"}, m_req, 0);
            check({tag, "_wait_aok"}, i_addr_ok | d_addr_ok, 0);
            m_data_ok = 1'b1;
            m_rdata   = rd;
            #1;
            resp(tag, inst, rd);
            tick();
            m_data_ok = 1'b0;
            m_rdata   = 32'h0;
        end
    endtask

    initial begin
        logic exp_inst;
        tick();
        tick();
        check("rst_mreq", m_req, 0);
        check("rst_maddr", m_addr, 0);
        check("rst_oks", {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok}, 0);
        check("rst_rdata", {i_rdata, d_rdata}, 0);
        rst = 1'b0;
        tick();

        // Single inst read, latency of exactly one cycle to m_req
        i_req  = 1'b1;
        i_addr = 32'hBFC00000;
        i_size = 2'd2;
        #1;
        check("t1_noaccept", m_req, 0);
        tick();
        check("t1_lat", m_req, 1);
        i_addr = 32'hDEADBEEF;
        serve("t1", 1'b1, 32'hBFC00000, 1'b0, 32'h3C1DBFC0, 1'b1);
        check("t1_size", m_size, 2);

        // Simultaneous requests: data first, then inst
        tick();
        d_req  = 1'b1;
        d_addr = 32'h80000040;
        i_req  = 1'b1;
        i_addr = 32'hBFC00004;
        serve("t2d", 1'b0, 32'h80000040, 1'b0, 32'h11112222, 1'b1);
        serve("t2i", 1'b1, 32'hBFC00004, 1'b0, 32'h33334444, 1'b1);

        // Data word write with same-cycle addr_ok and data_ok
        tick();
        d_req   = 1'b1;
        d_wr    = 1'b1;
        d_size  = 2'd2;
        d_addr  = 32'h80001000;
        d_wdata = 32'hCAFEF00D;
        serve("t3", 1'b0, 32'h80001000, 1'b1, 32'h0, 1'b1);
        check("t3_wr", m_wr, 1);
        check("t3_wdata", m_wdata, 32'hCAFEF00D);
        check("t3_idle_mreq", m_req, 0);
        d_wr = 1'b0;
        tick();
        check("t3_stay_idle", m_req, 0);

        // Both held high: grant order
        d_addr = 32'h80002000;
        i_addr = 32'hBFC00100;
        d_req  = 1'b1;
        i_req  = 1'b1;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_EN
            exp_inst = (k == 4 || k == 9);
`else
            exp_inst = 1'b0;
`endif
            serve($sformatf("t4_g%0d", k), exp_inst, exp_inst ? 32'hBFC00100 : 32'h80002000,
                  1'b0, 32'h1000 + k, 1'b0);
        end
        d_req = 1'b0;
        serve("t4_last", 1'b1, 32'hBFC00100, 1'b0, 32'h55AA55AA, 1'b1);

        // Async reset while in WAIT
        tick();
        i_req  = 1'b1;
        i_addr = 32'hBFC00010;
        tick();
        tick();
        check("t5_mreq", m_req, 1);
        m_addr_ok = 1'b1;
        tick();
        m_addr_ok = 1'b0;
        i_req     = 1'b0;
        m_data_ok = 1'b1;
        rst       = 1'b1;
        #1;
        check("t5_rst_idok", i_data_ok, 0);
        check("t5_rst_mreq", m_req, 0);
        check("t5_rst_maddr", m_addr, 0);
        tick();
        m_data_ok = 1'b0;
        rst       = 1'b0;
        tick();
        i_req  = 1'b1;
        i_addr = 32'hBFC00020;
        serve("t5_fresh", 1'b1, 32'hBFC00020, 1'b0, 32'h0BADCAFE, 1'b1);

        // Spurious m_data_ok in IDLE
        tick();
        m_data_ok = 1'b1;
        m_rdata   = 32'h0;
        #1;
        check("t6_spur_oks", {i_data_ok, d_data_ok, i_addr_ok, d_addr_ok}, 0);
        tick();
        m_data_ok = 1'b0;
        check("t6_spur_mreq", m_req, 0);
        d_req  = 1'b1;
        d_addr = 32'h80003000;
        serve("t6", 1'b0, 32'h80003000, 1'b0, 32'h76543210, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
